// File: rtl/rr_arb4_pkg.sv
// Shared types, constants and the round-robin search for rr_arb4.
package rr_arb4_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set request scanning LAST+1, LAST+2, LAST+3, LAST (mod 4).
    function automatic rr_pick_t rr_search(input logic [NUM_REQ-1:0] req,
                                           input logic [IDX_W-1:0]   last);
        rr_pick_t         pick;
        logic [IDX_W-1:0] cand;
        pick = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = last + IDX_W'(i);
            if (!pick.found && req[cand]) begin
                pick.found = 1'b1;
                pick.idx   = cand;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arb4_dec24.sv
// 2-to-4 enable decoder: one-hot of in when en is high, else all zero.
module rr_arb4_dec24 import rr_arb4_pkg::*; (
    input  logic               en,
    input  logic [IDX_W-1:0]   in,
    output logic [NUM_REQ-1:0] out
);

    // Decode index to one-hot, gated by enable.
    always_comb begin
        out = '0;
        if (en) begin
            out[in] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with break-before-make registered grants.
// Optional hold timeout compiled in with macro RR_ARB4_TIMEOUT_EN.
module rr_arb4 import rr_arb4_pkg::*; #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_REQ-1:0] REQ,
    output logic [NUM_REQ-1:0] GNT,
    output logic [IDX_W-1:0]   GNT_IDX,
    output logic               GNT_VLD,
    output logic               TMO
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arb4: MAX_HOLD must be in 1..255");
    end

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   idx_d;
    logic               vld_d;
    logic               tmo_d;
    logic [NUM_REQ-1:0] gnt_d;
    rr_pick_t           pick;

`ifdef RR_ARB4_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign pick = rr_search(REQ, last_q);

    // Next-state and next-output logic for the IDLE/BUSY arbiter.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        idx_d   = GNT_IDX;
        vld_d   = 1'b0;
        tmo_d   = 1'b0;
`ifdef RR_ARB4_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick.found) begin
                    state_d = BUSY;
                    idx_d   = pick.idx;
                    vld_d   = 1'b1;
`ifdef RR_ARB4_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUSY: begin
                if (!REQ[GNT_IDX]) begin
                    state_d = IDLE;
                    last_d  = GNT_IDX;
                end
`ifdef RR_ARB4_TIMEOUT_EN
                else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
                    state_d = IDLE;
                    last_d  = GNT_IDX;
                    tmo_d   = 1'b1;
                end
`endif
                else begin
                    vld_d = 1'b1;
`ifdef RR_ARB4_TIMEOUT_EN
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One-hot grant decoded from the next index/valid so GNT lines up with GNT_IDX.
    rr_arb4_dec24 u_dec (
        .en  (vld_d),
        .in  (idx_d),
        .out (gnt_d)
    );

    // State and output registers; reset wins over everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            last_q  <= IDX_W'(NUM_REQ - 1);
            GNT     <= '0;
            GNT_IDX <= '0;
            GNT_VLD <= 1'b0;
            TMO     <= 1'b0;
`ifdef RR_ARB4_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            GNT     <= gnt_d;
            GNT_IDX <= idx_d;
            GNT_VLD <= vld_d;
            TMO     <= tmo_d;
`ifdef RR_ARB4_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_rr_arb4.sv
// Self-checking bench for rr_arb4: per-cycle behavioural model plus literal checks.
module tb_rr_arb4;

    localparam int TB_MAX_HOLD = 4;
`ifdef RR_ARB4_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_vld;
    logic       tmo;

    int   errors = 0;
    int   checks = 0;
    logic chk_en = 1'b0;

    // Model state: current owner (-1 = none), last holder, cycles held, shown index, tmo.
    int         m_owner = -1;
    int         m_last  = 3;
    int         m_held  = 0;
    logic [1:0] m_idx   = 2'd0;
    logic       m_tmo   = 1'b0;

    rr_arb4 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
        .CLK     (clk),
        .RST     (rst),
        .REQ     (req),
        .GNT     (gnt),
        .GNT_IDX (gnt_idx),
        .GNT_VLD (gnt_vld),
        .TMO     (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the resource after each edge.
    always @(posedge clk) begin : model
        int         o;
        int         l;
        int         h;
        int         c;
        logic       t;
        logic [1:0] ix;
        o  = m_owner;
        l  = m_last;
        h  = m_held;
        ix = m_idx;
        t  = 1'b0;
        if (rst) begin
            o = -1; l = 3; h = 0; ix = 2'd0;
        end else if (o < 0) begin
            for (int k = 1; k <= 4; k++) begin
                c = (l + k) % 4;
                if (o < 0 && req[c]) begin
                    o = c; h = 1; ix = 2'(c);
                end
            end
        end else if (!req[o]) begin
            l = o; o = -1;
        end else if (TMO_EN && h == TB_MAX_HOLD) begin
            l = o; o = -1; t = 1'b1;
        end else begin
            h = h + 1;
        end
        m_owner <= o;
        m_last  <= l;
        m_held  <= h;
        m_idx   <= ix;
        m_tmo   <= t;
    end

    // Compare DUT outputs against the model mid-cycle.
    always @(negedge clk) begin : compare
        logic [3:0] eg;
        if (chk_en) begin
            eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
            check("model_gnt", 32'(gnt), 32'(eg));
            check("model_idx", 32'(gnt_idx), 32'(m_idx));
            check("model_vld", 32'(gnt_vld), 32'(m_owner >= 0));
            check("model_tmo", 32'(tmo), 32'(m_tmo));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [3:0] g, input logic [1:0] ix,
                       input logic v, input logic t);
        @(negedge clk);
        check({nm, "_gnt"}, 32'(gnt), 32'(g));
        check({nm, "_idx"}, 32'(gnt_idx), 32'(ix));
        check({nm, "_vld"}, 32'(gnt_vld), 32'(v));
        check({nm, "_tmo"}, 32'(tmo), 32'(t));
    endtask

    initial begin
        // Reset held two edges with all clients requesting.
        rst = 1'b1;
        req = 4'b1111;
        tick();
        chk_en = 1'b1;
        lit("rst1", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        lit("rst2", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        lit("first", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Fairness: each holder keeps 3 cycles, drops for one.
        for (int k = 0; k < 4; k++) begin
            tick();
            tick();
            req = 4'b1111 & ~(4'b0001 << k);
            tick();
            lit("fair_gap", 4'b0000, 2'(k), 1'b0, 1'b0);
            req = 4'b1111;
            tick();
            lit("fair_next", 4'b0001 << ((k + 1) % 4), 2'((k + 1) % 4), 1'b1, 1'b0);
        end

        // Wrap and skip: make client 3 the last holder, then REQ = 1010.
        req = 4'b0000; tick();
        req = 4'b1000; tick();
        req = 4'b0000; tick();
        req = 4'b1010; tick();
        lit("wrap1", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b1000; tick();
        lit("wrap_gap1", 4'b0000, 2'd1, 1'b0, 1'b0);
        req = 4'b1010; tick();
        lit("wrap2", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b0010; tick();
        lit("wrap_gap2", 4'b0000, 2'd3, 1'b0, 1'b0);
        req = 4'b1010; tick();
        lit("wrap3", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0000; tick();

        // Single client 2 requesting cycles 0..4, dropped at cycle 5.
        req = 4'b0100; tick();
        lit("single_c1", 4'b0100, 2'd2, 1'b1, 1'b0);
        tick(); tick(); tick();
        lit("single_c4", 4'b0100, 2'd2, 1'b1, 1'b0);
        tick();
`ifdef RR_ARB4_TIMEOUT_EN
        lit("single_c5", 4'b0000, 2'd2, 1'b0, 1'b1);
`else
        lit("single_c5", 4'b0100, 2'd2, 1'b1, 1'b0);
`endif
        req = 4'b0000; tick();
        lit("single_c6", 4'b0000, 2'd2, 1'b0, 1'b0);

        // Timeout scenario: make client 0 last, then hold REQ = 1010.
        req = 4'b0001; tick();
        req = 4'b0000; tick();
        req = 4'b1010; tick();
        lit("hold_g1", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick(); tick(); tick();
        lit("hold_g4", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick();
`ifdef RR_ARB4_TIMEOUT_EN
        lit("hold_g5", 4'b0000, 2'd1, 1'b0, 1'b1);
        tick();
        lit("hold_g6", 4'b1000, 2'd3, 1'b1, 1'b0);
`else
        lit("hold_g5", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick();
        lit("hold_g6", 4'b0010, 2'd1, 1'b1, 1'b0);
`endif
        req = 4'b0000; tick(); tick();

        // Reset mid-grant: last holder before is 1, so a stale pointer would pick 2.
        req = 4'b0010; tick();
        req = 4'b0000; tick();
        req = 4'b0100; tick();
        lit("prerst_g1", 4'b0100, 2'd2, 1'b1, 1'b0);
        tick();
        rst = 1'b1;
        req = 4'b0110;
        tick();
        lit("midrst", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        lit("postrst", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0000; tick(); tick();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
